ret_addr_stack: RTL and testbench

Parametrised return-address stack for the CPU's branch/return path, successor to the fixed stack in the execute stage. It is generalised in address width, depth and overflow policy. It adds a single-level checkpoint/restore of the stack pointer so that a pipeline flush after a mispredicted call or return can undo speculative pushes and pops. It sits beside the execute-stage ALU:

- `push` is driven by save-address instructions, with `pc + 1` on `push_data`.
- `pop` is driven by `ret`.
- `top` feeds the branch-target mux.

---
 rtl/ras_pkg.sv | 13 +
 rtl/ras_mem.sv | 30 +++
 rtl/ret_addr_stack.sv | 145 ++++++++++++++
 tb/tb_ret_addr_stack.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ras_pkg.sv
// Shared definitions for the return-address stack and its users in the
// execute stage.
package ras_pkg;

   // Overflow policy selector values for the OVF_MODE parameter.
   localparam int OVF_WRAP = 0;   // push when full overwrites the oldest entry
   localparam int OVF_SAT  = 1;   // push when full is dropped

   // Configuration the execute stage instantiates the stack with.
   localparam int RAS_ADDR_W = 16;
   localparam int RAS_DEPTH  = 8;

endpackage : ras_pkg

// File: rtl/ras_mem.sv
// DEPTH x ADDR_W register array: one synchronous write port and one
// asynchronous read port. Contents are not reset; the owner never exposes
// an entry that has not been written since the stack was last emptied.
module ras_mem
   import ras_pkg::*;
#(
   parameter int ADDR_W = RAS_ADDR_W,
   parameter int DEPTH  = RAS_DEPTH,
   parameter int PTR_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [PTR_W-1:0]  waddr_i,
   input  logic [ADDR_W-1:0] wdata_i,
   input  logic [PTR_W-1:0]  raddr_i,
   output logic [ADDR_W-1:0] rdata_o
);

   logic [ADDR_W-1:0] mem_q [DEPTH];

   // Write port: one entry per cycle when enabled.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule : ras_mem

// File: rtl/ret_addr_stack.sv
// Return-address stack with configurable overflow policy and a single-level
// checkpoint of the pointer/count so a flush can undo speculative pushes and
// pops. There is no handshake: every push, pop, save and restore is accepted
// in the cycle it is presented, and the outputs top/valid/count are a
// combinational view of the state after the last rising edge.
module ret_addr_stack
   import ras_pkg::*;
#(
   parameter int ADDR_W   = RAS_ADDR_W,
   parameter int DEPTH    = RAS_DEPTH,
   parameter int OVF_MODE = OVF_WRAP,
   localparam int PTR_W   = $clog2(DEPTH),
   localparam int CNT_W   = PTR_W + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [ADDR_W-1:0] push_data,
   input  logic              pop,
   input  logic              ckpt_save,
   input  logic              ckpt_restore,
   output logic [ADDR_W-1:0] top,
   output logic              valid,
   output logic [CNT_W-1:0]  count,
   output logic              ovf,
   output logic              unf
);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [PTR_W-1:0]  tos_q, tos_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [PTR_W-1:0]  ck_tos_q, ck_tos_d;
   logic [CNT_W-1:0]  ck_count_q, ck_count_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;

   logic              we;
   logic [PTR_W-1:0]  waddr;
   logic [PTR_W-1:0]  top_idx;
   logic [ADDR_W-1:0] rdata;
   logic              empty;
   logic              full;

   assign empty   = (count_q == '0);
   assign full    = (count_q == FULL_CNT);
   assign top_idx = tos_q - PTR_ONE;

   // Next-state for pointer, count and flags: restore beats push/pop.
   always_comb begin
      tos_d   = tos_q;
      count_d = count_q;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
      we      = 1'b0;
      waddr   = tos_q;
      if (ckpt_restore) begin
         tos_d   = ck_tos_q;
         count_d = ck_count_q;
      end else if (push && pop) begin
         if (empty) begin
            // Pop has nothing to remove; the push still goes in.
            unf_d   = 1'b1;
            we      = 1'b1;
            tos_d   = tos_q + PTR_ONE;
            count_d = CNT_ONE;
         end else begin
            // Replace the top entry in place; depth unchanged, never overflows.
            we    = 1'b1;
            waddr = top_idx;
         end
      end else if (push) begin
         if (!full) begin
            we      = 1'b1;
            tos_d   = tos_q + PTR_ONE;
            count_d = count_q + CNT_ONE;
         end else begin
            ovf_d = 1'b1;
            if (OVF_MODE == OVF_WRAP) begin
               // Ring buffer: the slot at tos holds the oldest entry.
               we    = 1'b1;
               tos_d = tos_q + PTR_ONE;
            end
         end
      end else if (pop) begin
         if (empty) begin
            unf_d = 1'b1;
         end else begin
            tos_d   = tos_q - PTR_ONE;
            count_d = count_q - CNT_ONE;
         end
      end
   end

   // Snapshot captures post-update values, so a save+restore keeps the restore.
   always_comb begin
      ck_tos_d   = ck_tos_q;
      ck_count_d = ck_count_q;
      if (ckpt_save) begin
         ck_tos_d   = tos_d;
         ck_count_d = count_d;
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tos_q      <= '0;
         count_q    <= '0;
         ck_tos_q   <= '0;
         ck_count_q <= '0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
      end else begin
         tos_q      <= tos_d;
         count_q    <= count_d;
         ck_tos_q   <= ck_tos_d;
         ck_count_q <= ck_count_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
      end
   end

   ras_mem #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH),
      .PTR_W  (PTR_W)
   ) u_mem (
      .clk     (clk),
      .we_i    (we),
      .waddr_i (waddr),
      .wdata_i (push_data),
      .raddr_i (top_idx),
      .rdata_o (rdata)
   );

   assign top   = empty ? '0 : rdata;
   assign valid = !empty;
   assign count = count_q;
   assign ovf   = ovf_q;
   assign unf   = unf_q;

endmodule : ret_addr_stack

// File: tb/tb_ret_addr_stack.sv
// Directed bench for ret_addr_stack at DEPTH = 4. Two instances share the
// stimulus: one with the wrap overflow policy, one saturating.
module tb_ret_addr_stack;

   localparam int ADDR_W = 16;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = $clog2(DEPTH) + 1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst = 1'b1;
   logic              push = 1'b0;
   logic [ADDR_W-1:0] push_data = '0;
   logic              pop = 1'b0;
   logic              ckpt_save = 1'b0;
   logic              ckpt_restore = 1'b0;

   logic [ADDR_W-1:0] top_w, top_s;
   logic              valid_w, valid_s;
   logic [CNT_W-1:0]  count_w, count_s;
   logic              ovf_w, ovf_s, unf_w, unf_s;

   int n_cmp = 0;
   int n_err = 0;

   ret_addr_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .OVF_MODE(0)) dut_wrap (
      .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
      .ckpt_save(ckpt_save), .ckpt_restore(ckpt_restore),
      .top(top_w), .valid(valid_w), .count(count_w), .ovf(ovf_w), .unf(unf_w)
   );

   ret_addr_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .OVF_MODE(1)) dut_sat (
      .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
      .ckpt_save(ckpt_save), .ckpt_restore(ckpt_restore),
      .top(top_s), .valid(valid_s), .count(count_s), .ovf(ovf_s), .unf(unf_s)
   );

   // ---------------- driver tasks ----------------
   // Apply one cycle of controls, clock it, release controls, sample at +1.
   task automatic cycle(input logic p, input logic q, input logic [ADDR_W-1:0] d,
                        input logic sv, input logic rs);
      push = p; pop = q; push_data = d; ckpt_save = sv; ckpt_restore = rs;
      @(posedge clk);
      #1;
      push = 1'b0; pop = 1'b0; ckpt_save = 1'b0; ckpt_restore = 1'b0;
   endtask

   task automatic do_push(input logic [ADDR_W-1:0] d); cycle(1'b1, 1'b0, d, 1'b0, 1'b0); endtask
   task automatic do_pop();                            cycle(1'b0, 1'b1, '0, 1'b0, 1'b0); endtask
   task automatic do_pushpop(input logic [ADDR_W-1:0] d); cycle(1'b1, 1'b1, d, 1'b0, 1'b0); endtask
   task automatic do_idle();                           cycle(1'b0, 1'b0, '0, 1'b0, 1'b0); endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      apply_reset();
      n_cmp++; if (count_w !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", count_w); end
      n_cmp++; if (valid_w !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", valid_w); end
      n_cmp++; if (top_w !== 16'h0) begin n_err++; $display("FAIL reset_top: got %h expected 0000", top_w); end
      n_cmp++; if ({ovf_w, unf_w, ovf_s, unf_s} !== 4'b0) begin n_err++; $display("FAIL reset_flags: got %b expected 0000", {ovf_w, unf_w, ovf_s, unf_s}); end
   endtask

   task automatic test_push_pop();
      apply_reset();
      do_push(16'h0011); do_push(16'h0022); do_push(16'h0033);
      n_cmp++; if (top_w !== 16'h0033) begin n_err++; $display("FAIL pp_top3: got %h expected 0033", top_w); end
      n_cmp++; if (count_w !== 3'd3) begin n_err++; $display("FAIL pp_count3: got %0d expected 3", count_w); end
      n_cmp++; if (valid_w !== 1'b1) begin n_err++; $display("FAIL pp_valid: got %b expected 1", valid_w); end
      do_pop(); do_pop();
      n_cmp++; if (top_w !== 16'h0011) begin n_err++; $display("FAIL pp_top1: got %h expected 0011", top_w); end
      n_cmp++; if (count_w !== 3'd1) begin n_err++; $display("FAIL pp_count1: got %0d expected 1", count_w); end
   endtask

   task automatic test_wrap();
      logic [ADDR_W-1:0] exp_top [4];
      exp_top[0] = 16'h5; exp_top[1] = 16'h4; exp_top[2] = 16'h3; exp_top[3] = 16'h2;
      apply_reset();
      for (int i = 1; i <= 4; i++) begin
         do_push(ADDR_W'(i));
         n_cmp++; if (ovf_w !== 1'b0) begin n_err++; $display("FAIL wrap_no_ovf_%0d: got %b expected 0", i, ovf_w); end
      end
      do_push(16'h5);
      n_cmp++; if (ovf_w !== 1'b1) begin n_err++; $display("FAIL wrap_ovf: got %b expected 1", ovf_w); end
      n_cmp++; if (count_w !== 3'd4) begin n_err++; $display("FAIL wrap_count: got %0d expected 4", count_w); end
      n_cmp++; if (top_w !== 16'h5) begin n_err++; $display("FAIL wrap_top: got %h expected 0005", top_w); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (top_w !== exp_top[i]) begin n_err++; $display("FAIL wrap_pop_top_%0d: got %h expected %h", i, top_w, exp_top[i]); end
         do_pop();
         if (i == 0) begin
            n_cmp++; if (ovf_w !== 1'b0) begin n_err++; $display("FAIL wrap_ovf_pulse: got %b expected 0", ovf_w); end
         end
      end
      n_cmp++; if (count_w !== 3'd0) begin n_err++; $display("FAIL wrap_empty_count: got %0d expected 0", count_w); end
      n_cmp++; if (top_w !== 16'h0) begin n_err++; $display("FAIL wrap_empty_top: got %h expected 0000", top_w); end
   endtask

   task automatic test_sat();
      apply_reset();
      for (int i = 1; i <= 4; i++) do_push(ADDR_W'(i));
      n_cmp++; if (ovf_s !== 1'b0) begin n_err++; $display("FAIL sat_no_ovf: got %b expected 0", ovf_s); end
      do_push(16'h5);
      n_cmp++; if (ovf_s !== 1'b1) begin n_err++; $display("FAIL sat_ovf: got %b expected 1", ovf_s); end
      n_cmp++; if (top_s !== 16'h4) begin n_err++; $display("FAIL sat_top: got %h expected 0004", top_s); end
      n_cmp++; if (count_s !== 3'd4) begin n_err++; $display("FAIL sat_count: got %0d expected 4", count_s); end
      do_pushpop(16'h00AA);
      n_cmp++; if (top_s !== 16'h00AA) begin n_err++; $display("FAIL sat_replace_top: got %h expected 00aa", top_s); end
      n_cmp++; if (count_s !== 3'd4) begin n_err++; $display("FAIL sat_replace_count: got %0d expected 4", count_s); end
      n_cmp++; if (ovf_s !== 1'b0) begin n_err++; $display("FAIL sat_replace_ovf: got %b expected 0", ovf_s); end
      do_pop();
      n_cmp++; if (top_s !== 16'h3) begin n_err++; $display("FAIL sat_below_replace: got %h expected 0003", top_s); end
   endtask

   task automatic test_underflow();
      apply_reset();
      do_pop();
      n_cmp++; if (unf_w !== 1'b1) begin n_err++; $display("FAIL unf_pulse: got %b expected 1", unf_w); end
      n_cmp++; if (count_w !== 3'd0) begin n_err++; $display("FAIL unf_count: got %0d expected 0", count_w); end
      n_cmp++; if (top_w !== 16'h0) begin n_err++; $display("FAIL unf_top: got %h expected 0000", top_w); end
      do_idle();
      n_cmp++; if (unf_w !== 1'b0) begin n_err++; $display("FAIL unf_one_cycle: got %b expected 0", unf_w); end
      do_pushpop(16'h0077);
      n_cmp++; if (unf_w !== 1'b1) begin n_err++; $display("FAIL unf_pp_pulse: got %b expected 1", unf_w); end
      n_cmp++; if (top_w !== 16'h0077) begin n_err++; $display("FAIL unf_pp_top: got %h expected 0077", top_w); end
      n_cmp++; if (count_w !== 3'd1) begin n_err++; $display("FAIL unf_pp_count: got %0d expected 1", count_w); end
   endtask

   task automatic test_ckpt();
      apply_reset();
      do_push(16'h0010);
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);            // save alone
      do_push(16'h0020); do_pop(); do_pop();
      n_cmp++; if (count_w !== 3'd0) begin n_err++; $display("FAIL ck_spec_count: got %0d expected 0", count_w); end
      cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);            // restore
      n_cmp++; if (count_w !== 3'd1) begin n_err++; $display("FAIL ck_restore_count: got %0d expected 1", count_w); end
      n_cmp++; if (top_w !== 16'h0010) begin n_err++; $display("FAIL ck_restore_top: got %h expected 0010", top_w); end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      cycle(1'b1, 1'b0, 16'h0040, 1'b1, 1'b0);      // save with push: snapshot count 1
      do_push(16'h0050);
      cycle(1'b1, 1'b0, 16'h0060, 1'b0, 1'b1);      // restore ignores the push
      n_cmp++; if (count_w !== 3'd1) begin n_err++; $display("FAIL b2b_count: got %0d expected 1", count_w); end
      n_cmp++; if (top_w !== 16'h0040) begin n_err++; $display("FAIL b2b_top: got %h expected 0040", top_w); end
      do_push(16'h0070);
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);            // save+restore: snapshot stays count 1
      n_cmp++; if (count_w !== 3'd1) begin n_err++; $display("FAIL b2b_sr_count: got %0d expected 1", count_w); end
      do_push(16'h0080); do_push(16'h0090);
      cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
      n_cmp++; if (count_w !== 3'd1) begin n_err++; $display("FAIL b2b_sr_kept: got %0d expected 1", count_w); end
      n_cmp++; if (top_w !== 16'h0040) begin n_err++; $display("FAIL b2b_sr_top: got %h expected 0040", top_w); end
   endtask

   task automatic test_async_reset();
      apply_reset();
      do_push(16'h0001); do_push(16'h0002); do_push(16'h0003);
      n_cmp++; if (count_w !== 3'd3) begin n_err++; $display("FAIL ar_pre_count: got %0d expected 3", count_w); end
      #2 rst = 1'b1;                                // mid-cycle, no edge yet
      #1;
      n_cmp++; if (count_w !== 3'd0) begin n_err++; $display("FAIL ar_count: got %0d expected 0", count_w); end
      n_cmp++; if (valid_w !== 1'b0) begin n_err++; $display("FAIL ar_valid: got %b expected 0", valid_w); end
      n_cmp++; if (top_w !== 16'h0) begin n_err++; $display("FAIL ar_top: got %h expected 0000", top_w); end
      @(negedge clk);
      rst = 1'b0;
      do_push(16'h0005);
      n_cmp++; if (top_w !== 16'h0005) begin n_err++; $display("FAIL ar_push_top: got %h expected 0005", top_w); end
      n_cmp++; if (count_w !== 3'd1) begin n_err++; $display("FAIL ar_push_count: got %0d expected 1", count_w); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_push_pop();
      test_wrap();
      test_sat();
      test_underflow();
      test_ckpt();
      test_back_to_back();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish before 100000");
      $fatal(1);
   end

endmodule : tb_ret_addr_stack
